// File: rtl/inst_entity2_if.sv
// Valid/ready stream bundle used on both sides of the bridge.
// master drives data/valid, slave drives ready.
interface inst_entity2_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/inst_entity2.sv
// Valid/ready FIFO bridge: s (producer, slave side) -> m (consumer, master side).
// Ports: clk, rst_n, flush, s/m stream bundles, level = stored word count.
module inst_entity2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  inst_entity2_if.slave            s,
  inst_entity2_if.master           m,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [LW-1:0]    cnt;
  logic             push;
  logic             pop;

  // Handshake flags come from cnt only, so no m.ready -> s.ready path.
  assign s.ready = (cnt != LW'(DEPTH));
  assign m.valid = (cnt != '0);
  assign m.data  = mem[rd_ptr];
  assign level   = cnt;

  assign push = s.valid && s.ready;
  assign pop  = m.valid && m.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        (push && !pop): cnt <= cnt + LW'(1);
        (pop && !push): cnt <= cnt - LW'(1);
        default:        cnt <= cnt;
      endcase
    end
  end

  // Storage is never cleared; flush only drops the pending write.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= s.data;
  end
endmodule

// File: tb/tb_inst_entity2.sv
// Directed bench for inst_entity2 with a queue scoreboard.
// Expected words are queued on modelled push and compared on output.
module tb_inst_entity2;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [$clog2(DEPTH):0] level;

  inst_entity2_if #(.WIDTH(WIDTH)) s_if ();
  inst_entity2_if #(.WIDTH(WIDTH)) m_if ();

  inst_entity2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .s     (s_if),
    .m     (m_if),
    .level (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check pre-edge outputs against the model,
  // clock, then update the model and check the level.
  task automatic step(input logic sv, input logic [WIDTH-1:0] sd,
                      input logic mr, input logic fl);
    int ml;
    logic mpush;
    logic mpop;
    s_if.valid = sv;
    s_if.data  = sd;
    m_if.ready = mr;
    flush      = fl;
    ml    = sb.size();
    mpush = sv && (ml != DEPTH) && !fl;
    mpop  = (ml != 0) && mr && !fl;
    #1;
    chk("s_ready", 64'(s_if.ready), 64'(ml != DEPTH));
    chk("m_valid", 64'(m_if.valid), 64'(ml != 0));
    if (ml != 0) chk("m_data", 64'(m_if.data), 64'(sb[0]));
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (mpop)  void'(sb.pop_front());
      if (mpush) sb.push_back(sd);
    end
    chk("level", 64'(level), 64'(sb.size()));
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    m_if.ready = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      s_if.valid = 1'($urandom);
      s_if.data  = $urandom;
      m_if.ready = 1'($urandom);
      flush      = 1'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_m_valid", 64'(m_if.valid), 64'd0);
    chk("rst_s_ready", 64'(s_if.ready), 64'd1);
    rst_n = 1'b1;

    // First push after reset.
    step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    chk("first_m_valid", 64'(m_if.valid), 64'd1);
    chk("first_m_data", 64'(m_if.data), 64'hA5A5_0001);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill with consumer stalled.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    chk("full_s_ready", 64'(s_if.ready), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h5, 1'b0, 1'b0);
    chk("full_level", 64'(level), 64'd4);

    // Full with simultaneous pop: 0x5 must wait a cycle.
    step(1'b1, 32'h5, 1'b1, 1'b0);
    chk("fp_level", 64'(level), 64'd3);
    chk("fp_s_ready", 64'(s_if.ready), 64'd1);
    step(1'b1, 32'h5, 1'b0, 1'b0);
    chk("fp_refill", 64'(level), 64'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_m_valid", 64'(m_if.valid), 64'd0);

    // Streaming with wrap.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'(i), 1'b1, 1'b0);
      chk("stream_level", 64'(level), 64'd1);
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush with a push and pop in the same cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b1, 1'b1);
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_m_valid", 64'(m_if.valid), 64'd0);
    step(1'b1, 32'hBEEF, 1'b0, 1'b0);
    chk("post_flush_data", 64'(m_if.data), 64'hBEEF);
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges at level 2.
    step(1'b1, 32'h77, 1'b0, 1'b0);
    step(1'b1, 32'h78, 1'b0, 1'b0);
    chk("pre_arst_level", 64'(level), 64'd2);
    s_if.valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_m_valid", 64'(m_if.valid), 64'd0);
    chk("arst_s_ready", 64'(s_if.ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 32'h99, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
